// File: rtl/demux_sched.sv
// demux_sched: single-entry holding stage that steers one nibble at a time
// to one of two demultiplexer lanes, with selectable lane routing.
//
// Ports:
//   inClk, inRst     clock and synchronous active-high reset
//   inData/inValid   upstream symbol; accepted when inValid && outReady
//   outReady         stage can take inData this cycle (combinational)
//   inMode           00 ping-pong, 01 lane0, 10 lane1, 11 first-ready
//   inFlush          drop the held symbol
//   inLaneReady      per-lane consumer ready (bit0 lane0, bit1 lane1)
//   outData/outSel   held symbol and its lane, drive the demultiplexer
//   outValid         one-hot lane valid, 00 when empty
//   outCount         delivered-symbol counter, wraps
//   outBusy          high while a symbol is held
module demux_sched #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             inClk,
  input  logic             inRst,
  input  logic [3:0]       inData,
  input  logic             inValid,
  output logic             outReady,
  input  logic [1:0]       inMode,
  input  logic             inFlush,
  input  logic [1:0]       inLaneReady,
  output logic [3:0]       outData,
  output logic             outSel,
  output logic [1:0]       outValid,
  output logic [CNT_W-1:0] outCount,
  output logic             outBusy
);

  localparam int unsigned DATA_W = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } stateT;

  stateT             state;
  stateT             stateNext;
  logic              ptr;
  logic              ptrNext;
  logic              ptrEff;
  logic              lane;
  logic              deliver;
  logic              accept;
  logic [DATA_W-1:0] dataNext;
  logic              selNext;
  logic [1:0]        validNext;
  logic [CNT_W-1:0]  countNext;
  logic              busyNext;

  // State and output registers
  always_ff @(posedge inClk) begin
    if (inRst) begin
      state    <= EMPTY;
      ptr      <= 1'b0;
      outData  <= '0;
      outSel   <= 1'b0;
      outValid <= 2'b00;
      outCount <= '0;
      outBusy  <= 1'b0;
    end else begin
      state    <= stateNext;
      ptr      <= ptrNext;
      outData  <= dataNext;
      outSel   <= selNext;
      outValid <= validNext;
      outCount <= countNext;
      outBusy  <= busyNext;
    end
  end

  // Handshake, lane choice and next-state logic
  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    dataNext  = outData;
    selNext   = outSel;
    countNext = outCount;
    lane      = 1'b0;

    // Flush wins over a same-cycle delivery
    deliver  = (state == HOLD) && inLaneReady[outSel] && !inFlush;
    outReady = !inRst && !inFlush &&
               ((state == EMPTY) || inLaneReady[outSel]);
    accept   = inValid && outReady;

    // Pointer as it stands after this cycle's delivery, so a back-to-back
    // accept lands on the opposite lane from the symbol leaving now
    ptrEff = ptr ^ (deliver && (inMode == 2'b00));

    unique case (inMode)
      2'b00:   lane = ptrEff;
      2'b01:   lane = 1'b0;
      2'b10:   lane = 1'b1;
      default: lane = inLaneReady[0] ? 1'b0 : (inLaneReady[1] ? 1'b1 : ptrEff);
    endcase

    if (deliver) begin
      countNext = outCount + CNT_W'(1);
      ptrNext   = ptrEff;
    end

    unique case (state)
      EMPTY: begin
        if (accept) stateNext = HOLD;
      end
      HOLD: begin
        if (inFlush)      stateNext = EMPTY;
        else if (deliver) stateNext = accept ? HOLD : EMPTY;
      end
      default: stateNext = EMPTY;
    endcase

    if (accept) begin
      dataNext = inData;
      selNext  = lane;
    end

    busyNext  = (stateNext == HOLD);
    validNext = busyNext ? {selNext, !selNext} : 2'b00;
  end

endmodule

// File: tb/tb_demux_sched.sv
// Directed self-checking bench for demux_sched.
module tb_demux_sched;

  localparam int unsigned CNT_W = 8;

  logic             inClk;
  logic             inRst;
  logic [3:0]       inData;
  logic             inValid;
  logic             outReady;
  logic [1:0]       inMode;
  logic             inFlush;
  logic [1:0]       inLaneReady;
  logic [3:0]       outData;
  logic             outSel;
  logic [1:0]       outValid;
  logic [CNT_W-1:0] outCount;
  logic             outBusy;

  int total = 0;
  int bad   = 0;

  demux_sched #(.CNT_W(CNT_W)) dut (
    .inClk       (inClk),
    .inRst       (inRst),
    .inData      (inData),
    .inValid     (inValid),
    .outReady    (outReady),
    .inMode      (inMode),
    .inFlush     (inFlush),
    .inLaneReady (inLaneReady),
    .outData     (outData),
    .outSel      (outSel),
    .outValid    (outValid),
    .outCount    (outCount),
    .outBusy     (outBusy)
  );

  initial inClk = 1'b0;
  always #5 inClk = ~inClk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge inClk);
    #1;
  endtask

  task automatic resetDut();
    inRst = 1'b1; inValid = 1'b0; inFlush = 1'b0; inData = 4'h0;
    inMode = 2'b00; inLaneReady = 2'b00;
    tick();
    inRst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    inRst = 1'b1; inValid = 1'b1; inFlush = 1'b0; inData = 4'hF;
    inMode = 2'b00; inLaneReady = 2'b11;
    tick();
    total++; if (outValid !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b exp=00", outValid); end
    total++; if (outCount !== 8'h00) begin bad++; $display("FAIL reset_count got=%h exp=00", outCount); end
    total++; if (outBusy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", outBusy); end
    total++; if (outReady !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", outReady); end
    inRst = 1'b0;
    #1;
    total++; if (outReady !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", outReady); end
    inValid = 1'b0;
  endtask

  task automatic test_ping_pong();
    logic [1:0] expV [4];
    expV[0] = 2'b01; expV[1] = 2'b10; expV[2] = 2'b01; expV[3] = 2'b10;
    resetDut();
    inMode = 2'b00; inLaneReady = 2'b11; inValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inData = 4'(i + 1);
      tick();
      total++; if (outValid !== expV[i]) begin bad++; $display("FAIL pp_valid%0d got=%b exp=%b", i, outValid, expV[i]); end
      total++; if (outData !== 4'(i + 1)) begin bad++; $display("FAIL pp_data%0d got=%h exp=%h", i, outData, 4'(i + 1)); end
      total++; if (outCount !== 8'(i)) begin bad++; $display("FAIL pp_count%0d got=%0d exp=%0d", i, outCount, i); end
    end
    inValid = 1'b0;
    tick();
    total++; if (outCount !== 8'd4) begin bad++; $display("FAIL pp_final_count got=%0d exp=4", outCount); end
    total++; if (outValid !== 2'b00) begin bad++; $display("FAIL pp_final_valid got=%b exp=00", outValid); end
  endtask

  task automatic test_stall();
    resetDut();
    inMode = 2'b01; inLaneReady = 2'b00; inValid = 1'b1; inData = 4'hA;
    tick();
    inValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (outReady !== 1'b0) begin bad++; $display("FAIL stall_ready%0d got=%b exp=0", i, outReady); end
      total++; if (outValid !== 2'b01) begin bad++; $display("FAIL stall_valid%0d got=%b exp=01", i, outValid); end
      total++; if (outData !== 4'hA) begin bad++; $display("FAIL stall_data%0d got=%h exp=a", i, outData); end
      total++; if (outCount !== 8'd0) begin bad++; $display("FAIL stall_count%0d got=%0d exp=0", i, outCount); end
      tick();
    end
    inLaneReady = 2'b01;
    #1;
    total++; if (outReady !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b exp=1", outReady); end
    total++; if (outValid !== 2'b01) begin bad++; $display("FAIL stall_release_valid got=%b exp=01", outValid); end
    tick();
    total++; if (outCount !== 8'd1) begin bad++; $display("FAIL stall_count_after got=%0d exp=1", outCount); end
    total++; if (outValid !== 2'b00) begin bad++; $display("FAIL stall_valid_after got=%b exp=00", outValid); end
  endtask

  task automatic test_first_ready();
    resetDut();
    inMode = 2'b11; inLaneReady = 2'b10; inValid = 1'b1; inData = 4'h5;
    tick();
    total++; if (outSel !== 1'b1) begin bad++; $display("FAIL fr_sel got=%b exp=1", outSel); end
    total++; if (outValid !== 2'b10) begin bad++; $display("FAIL fr_valid got=%b exp=10", outValid); end
    // Deliver in mode 00 so the pointer advances to 1
    inValid = 1'b0; inMode = 2'b00;
    tick();
    inMode = 2'b11; inLaneReady = 2'b00; inValid = 1'b1; inData = 4'h6;
    tick();
    total++; if (outSel !== 1'b1) begin bad++; $display("FAIL fr_ptr_sel got=%b exp=1", outSel); end
    total++; if (outData !== 4'h6) begin bad++; $display("FAIL fr_ptr_data got=%h exp=6", outData); end
    // Both lanes ready: lane0 preferred, back-to-back with the delivery of 0x6
    inLaneReady = 2'b11; inData = 4'h9;
    tick();
    inValid = 1'b0; inLaneReady = 2'b00;
    total++; if (outSel !== 1'b0) begin bad++; $display("FAIL fr_both_sel got=%b exp=0", outSel); end
    total++; if (outData !== 4'h9) begin bad++; $display("FAIL fr_both_data got=%h exp=9", outData); end
    total++; if (outCount !== 8'd2) begin bad++; $display("FAIL fr_count got=%0d exp=2", outCount); end
  endtask

  task automatic test_flush();
    resetDut();
    inMode = 2'b00; inLaneReady = 2'b00; inValid = 1'b1; inData = 4'h7;
    tick();
    total++; if (outValid !== 2'b01) begin bad++; $display("FAIL fl_hold_valid got=%b exp=01", outValid); end
    inFlush = 1'b1; inLaneReady = 2'b11; inData = 4'h8;
    #1;
    total++; if (outReady !== 1'b0) begin bad++; $display("FAIL fl_ready got=%b exp=0", outReady); end
    tick();
    total++; if (outValid !== 2'b00) begin bad++; $display("FAIL fl_valid got=%b exp=00", outValid); end
    total++; if (outCount !== 8'd0) begin bad++; $display("FAIL fl_count got=%0d exp=0", outCount); end
    total++; if (outBusy !== 1'b0) begin bad++; $display("FAIL fl_busy got=%b exp=0", outBusy); end
    total++; if (outReady !== 1'b0) begin bad++; $display("FAIL fl_empty_ready got=%b exp=0", outReady); end
    tick();
    total++; if (outBusy !== 1'b0) begin bad++; $display("FAIL fl_empty_busy got=%b exp=0", outBusy); end
    // Pointer must still be 0
    inFlush = 1'b0; inLaneReady = 2'b00; inData = 4'h3;
    tick();
    inValid = 1'b0;
    total++; if (outSel !== 1'b0) begin bad++; $display("FAIL fl_ptr_sel got=%b exp=0", outSel); end
    total++; if (outData !== 4'h3) begin bad++; $display("FAIL fl_ptr_data got=%h exp=3", outData); end
  endtask

  task automatic test_back_to_back_wrap();
    resetDut();
    inMode = 2'b01; inLaneReady = 2'b01; inValid = 1'b1; inData = 4'h1;
    tick();
    for (int i = 0; i < 255; i++) begin
      inData = 4'(i);
      tick();
    end
    total++; if (outCount !== 8'hFF) begin bad++; $display("FAIL wrap_pre got=%h exp=ff", outCount); end
    total++; if (outBusy !== 1'b1) begin bad++; $display("FAIL wrap_busy got=%b exp=1", outBusy); end
    inValid = 1'b0;
    tick();
    total++; if (outCount !== 8'h00) begin bad++; $display("FAIL wrap_post got=%h exp=00", outCount); end
  endtask

  task automatic test_reset_mid_hold();
    resetDut();
    inMode = 2'b00; inLaneReady = 2'b11; inValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inData = 4'(i + 1);
      tick();
    end
    inValid = 1'b0; inLaneReady = 2'b00;
    total++; if (outSel !== 1'b1) begin bad++; $display("FAIL rh_sel got=%b exp=1", outSel); end
    total++; if (outCount !== 8'd3) begin bad++; $display("FAIL rh_count got=%0d exp=3", outCount); end
    inRst = 1'b1; inLaneReady = 2'b11; inValid = 1'b1; inData = 4'hC;
    tick();
    total++; if (outValid !== 2'b00) begin bad++; $display("FAIL rh_valid got=%b exp=00", outValid); end
    total++; if (outCount !== 8'd0) begin bad++; $display("FAIL rh_count0 got=%0d exp=0", outCount); end
    total++; if (outData !== 4'h0) begin bad++; $display("FAIL rh_data got=%h exp=0", outData); end
    total++; if (outSel !== 1'b0) begin bad++; $display("FAIL rh_sel0 got=%b exp=0", outSel); end
    total++; if (outBusy !== 1'b0) begin bad++; $display("FAIL rh_busy got=%b exp=0", outBusy); end
    total++; if (outReady !== 1'b0) begin bad++; $display("FAIL rh_ready got=%b exp=0", outReady); end
    inRst = 1'b0; inLaneReady = 2'b00; inData = 4'h5;
    tick();
    inValid = 1'b0;
    total++; if (outSel !== 1'b0) begin bad++; $display("FAIL rh_post_sel got=%b exp=0", outSel); end
    total++; if (outValid !== 2'b01) begin bad++; $display("FAIL rh_post_valid got=%b exp=01", outValid); end
  endtask

  initial begin
    inRst = 1'b1; inValid = 1'b0; inFlush = 1'b0; inData = 4'h0;
    inMode = 2'b00; inLaneReady = 2'b00;
    test_reset();
    test_ping_pong();
    test_stall();
    test_first_ready();
    test_flush();
    test_back_to_back_wrap();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_sched.md
DEMUX_SCHED -- requirements
Module: demux_sched

Interface
REQ-001 Parameter CNT_W, default 8, width of the delivered-symbol counter.
REQ-002 inClk  input  1  sole clock; all state updates on rising edge.
REQ-003 inRst  input  1  synchronous, active-high reset.
REQ-004 inData  input  4  upstream symbol nibble.
REQ-005 inValid  input  1  upstream symbol valid.
REQ-006 outReady  output  1  block accepts inData this cycle.
REQ-007 inMode  input  2  routing mode: 00 ping-pong, 01 lane0 only, 10 lane1 only, 11 first-ready.
REQ-008 inFlush  input  1  discard held symbol.
REQ-009 inLaneReady  input  2  per-lane consumer ready, bit0 = lane0 (demux outData[3:0]), bit1 = lane1 (demux outData[7:4]).
REQ-010 outData  output  4  held symbol, drives the demultiplexer data input.
REQ-011 outSel  output  1  lane of held symbol, drives the demultiplexer select (0 = lane0, 1 = lane1).
REQ-012 outValid  output  2  one-hot lane valid; 00 when empty.
REQ-013 outCount  output  CNT_W  count of delivered symbols.
REQ-014 outBusy  output  1  high while a symbol is held.

Function
REQ-015 The block SHALL hold at most one symbol in a registered stage with two states: EMPTY and HOLD.
REQ-016 Accept condition: inValid && outReady; outReady = !inFlush && (EMPTY || (HOLD && inLaneReady[outSel])).
REQ-017 Delivery condition: HOLD && inLaneReady[outSel]; on delivery outCount increments by 1, wrapping from 2^CNT_W-1 to 0.
REQ-018 EMPTY -> HOLD on accept; HOLD -> EMPTY on delivery without accept; HOLD -> HOLD on delivery with simultaneous accept (back-to-back, one symbol per cycle throughput).
REQ-019 Latency: a symbol accepted in cycle N SHALL appear on outData/outValid in cycle N+1.
REQ-020 outValid SHALL equal 2'b01 when HOLD && outSel=0, 2'b10 when HOLD && outSel=1, 2'b00 when EMPTY.
REQ-021 Lane for a captured symbol is chosen at accept time from inMode sampled in that cycle; a mode change never re-routes a held symbol.
REQ-022 Mode 00: lane = ping-pong pointer; pointer toggles on each delivery made while inMode=00, and is otherwise unchanged.
REQ-023 Mode 01 forces lane0; mode 10 forces lane1; the pointer is unchanged.
REQ-024 Mode 11: lane0 if inLaneReady[0], else lane1 if inLaneReady[1], else the ping-pong pointer value.
REQ-025 inFlush in HOLD SHALL return to EMPTY next cycle without delivery, counter increment, or pointer toggle; flush has priority over a same-cycle delivery.
REQ-026 inFlush in EMPTY has no effect beyond forcing outReady low.
REQ-027 outData and outSel SHALL hold their values unchanged while in HOLD without delivery.
REQ-028 outBusy SHALL equal (state == HOLD).

Reset
REQ-029 inRst high at a clock edge SHALL set state EMPTY, outData=0, outSel=0, outValid=00, outCount=0, ping-pong pointer=0, overriding any concurrent accept, delivery or flush.
REQ-030 outReady SHALL be 0 while inRst is high and follows REQ-016 from the first cycle after release.
REQ-031 Reset asserted mid-HOLD SHALL discard the held symbol with no delivery counted.

Verification
REQ-032 Mode 00, inLaneReady=11, inValid continuous with 0x1,0x2,0x3,0x4 -> outValid 01,10,01,10 on consecutive cycles from cycle 1, outData 0x1..0x4, outCount=4.
REQ-033 Mode 01, 0xA accepted, inLaneReady=00 for 3 cycles then 01 -> outValid=01 held 4 cycles, outReady=0 during stall, outCount 0->1 at release.
REQ-034 Mode 11, inLaneReady=10 at accept of 0x5 -> outSel=1, outValid=10; inLaneReady=00 at accept with pointer=1 -> outSel=1.
REQ-035 HOLD with 0x7, inFlush=1 and inLaneReady=11 same cycle -> next cycle outValid=00, outCount unchanged, pointer unchanged, outReady=0 during flush cycle.
REQ-036 CNT_W=8, outCount=0xFF, one delivery -> outCount=0x00.
REQ-037 inRst=1 while HOLD with lane1, pointer=1, outCount=3 -> next cycle all outputs zero, pointer=0; first post-reset mode-00 symbol routes to lane0.
